mem_access_sequencer: RTL and testbench
=======================================

// Module: mem_access_sequencer
// PURPOSE
//  Memory-side stage of the multicycle RISC-V core, directly downstream of the main controller.
//  - Turns the controller's IRWrite / adrSrc / memWrite strobes into a req/ack transaction on a variable-latency unified memory.
//  - Latches the instruction register (instr, oldPC) and the memory data register (memData).
//  - Drives stall, which freezes the controller state register and gates PC/regfile writes until the access retires.
// PARAMETERS
//  XLEN      32            data/address width
//  TIMEOUT   255           max cycles in BUSY before abort (>=1)
//  NOP_INSTR 32'h00000013  instr value loaded on reset and on fetch timeout
// PORTS
//  clk       in   1     clock, all state on rising edge
//  rst       in   1     synchronous, active-low reset
//  IRWrite   in   1     controller: instruction fetch this state
//  adrSrc    in   1     controller: data access (address = result)
//  memWrite  in   1     controller: data access is a store (valid only with adrSrc)
//  PC        in   XLEN  current PC (fetch address)
//  result    in   XLEN  data address from result mux
//  writeData in   XLEN  store data (rs2 register)
//  instr     out  XLEN  instruction register
//  oldPC     out  XLEN  PC of the fetched instruction
//  memData   out  XLEN  load data register
//  stall     out  1     1 = hold controller state; block PCUpdate/regWrite/IRWrite side effects
//  busErr    out  1     sticky: an access timed out
//  memReq    out  1     memory request, held until memAck
//  memWe     out  1     request is a write
//  memAddr   out  XLEN  word address, bits[1:0] forced 0
//  memWdata  out  XLEN  write data
//  memRdata  in   XLEN  read data, valid with memAck
//  memAck    in   1     memory completion, one-cycle pulse
// BEHAVIOUR
//  - access = IRWrite | adrSrc. If both are set, the fetch wins.
//  - Kind: FETCH (IRWrite), LOAD (adrSrc & ~memWrite), STORE (adrSrc & memWrite).
//  - FSM states: IDLE, BUSY, DONE.
//  - IDLE:
//    - If access: latch kind; memAddr <= {addr[XLEN-1:2],2'b00} with addr = FETCH ? PC : result.
//    - Latch memWe <= STORE; memWdata <= writeData. On FETCH, oldPC <= PC.
//    - Set memReq <= 1, clear the timeout counter, go to BUSY.
//    - If no access: stay in IDLE.
//  - BUSY:
//    - memReq, memAddr, memWe, memWdata are held stable.
//    - On memAck: FETCH: instr <= memRdata. LOAD: memData <= memRdata. STORE: no register update.
//    - On memAck: memReq <= 0, memWe <= 0, go to DONE.
//    - Without memAck: the counter increments. When count == TIMEOUT-1 with no ack: memReq <= 0, busErr <= 1, go to DONE.
//    - On timeout, FETCH loads instr <= NOP_INSTR. LOAD leaves memData unchanged.
//  - DONE: access inputs are ignored (the controller still presents the same state). Unconditionally go to IDLE.
//  - stall is combinational: IDLE = access; BUSY = 1; DONE = 0.
//    - Net effect: every memory state lasts >= 3 cycles; its side effects commit on the DONE cycle.
//  - memAck while IDLE or DONE is spurious and ignored; it does not alter any register.
//  - memAck and timeout in the same cycle: memAck wins, no busErr.
//  - busErr is cleared only by reset.
//  - Reset, including mid-BUSY: the request is abandoned; the memory must tolerate memReq dropping.
//    - State IDLE, memReq 0, memWe 0, memAddr 0, memWdata 0, instr NOP_INSTR, oldPC 0, memData 0, busErr 0, counter 0.
// STRUCTURE
//  - Shared defines header (`define, as with controller opcodes/states), containing:
//    - FSM state codes MS_IDLE/MS_BUSY/MS_DONE (2 bits)
//    - access kinds AK_FETCH/AK_LOAD/AK_STORE
//    - NOP_INSTR value
//  - One sub-module: mem_timeout_counter (clear, enable, terminal-count output, width $clog2(TIMEOUT+1)).
//  - Remaining logic is one FSM plus datapath registers.
// TESTING
//  1. Fetch, PC=0x40, ack 2 cycles after memReq rises, memRdata=0x00500093:
//     memAddr=0x40, memWe=0; stall high 3 cycles, low on the 4th; instr=0x00500093; oldPC=0x40.
//  2. Load, adrSrc=1, result=0x106, ack in the first BUSY cycle, memRdata=0xDEADBEEF:
//     memAddr=0x104; memData=0xDEADBEEF; instr unchanged; stall high exactly 2 cycles.
//  3. Store, adrSrc=1, memWrite=1, result=0x200, writeData=0x12345678, ack after 4 cycles:
//     memWe=1 with memWdata=0x12345678 held all BUSY cycles; memData and instr unchanged.
//  4. Fetch, TIMEOUT=4, no ack:
//     memReq drops after 4 BUSY cycles; busErr=1 and stays 1; instr=0x00000013; stall releases in DONE.
//  5. rst=0 on the second BUSY cycle of a load:
//     next edge gives memReq=0, state IDLE, memData=0, busErr=0. A late memAck after reset is ignored.
//  6. Spurious memAck in IDLE and in DONE, and IRWrite+adrSrc asserted together:
//     no register change from the spurious acks; the dual strobe is treated as FETCH at address PC.

Source files
------------

// File: rtl/mem_access_sequencer_pkg.sv
// Shared types and constants for the memory-access sequencer.
package mem_access_sequencer_pkg;

    localparam int unsigned XLEN_DEFAULT      = 32;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Sequencer FSM state codes
    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_BUSY = 2'd1,
        MS_DONE = 2'd2
    } ms_state_e;

    // Kind of memory access requested by the controller
    typedef enum logic [1:0] {
        AK_FETCH = 2'd0,
        AK_LOAD  = 2'd1,
        AK_STORE = 2'd2
    } access_kind_e;

    // Fetch has priority over a data access when both strobes are set
    function automatic access_kind_e decode_kind(input logic ir_write, input logic mem_write);
        if (ir_write) begin
            return AK_FETCH;
        end
        return mem_write ? AK_STORE : AK_LOAD;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Request/acknowledge bus between the sequencer and unified memory.
interface mem_access_sequencer_if
    import mem_access_sequencer_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
);

    logic            memReq;
    logic            memWe;
    logic [XLEN-1:0] memAddr;
    logic [XLEN-1:0] memWdata;
    logic [XLEN-1:0] memRdata;
    logic            memAck;

    modport master (
        output memReq,
        output memWe,
        output memAddr,
        output memWdata,
        input  memRdata,
        input  memAck
    );

    modport slave (
        input  memReq,
        input  memWe,
        input  memAddr,
        input  memWdata,
        output memRdata,
        output memAck
    );

endinterface

// File: rtl/mem_access_sequencer_timeout.sv
// Cycle counter bounding how long one memory access may stay outstanding.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // Count waiting cycles; clear takes priority over enable
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    // Terminal count: the last waiting cycle before abort
    always_comb begin
        tc_c = (count == CW'(TIMEOUT - 1));
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Memory stage of the multicycle core: turns controller strobes into a
// req/ack memory transaction, holds IR/oldPC/MDR and stalls the controller.
module mem_access_sequencer
    import mem_access_sequencer_pkg::*;
#(
    parameter int unsigned    XLEN      = XLEN_DEFAULT,
    parameter int unsigned    TIMEOUT   = 255,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            IRWrite,
    input  logic            adrSrc,
    input  logic            memWrite,
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] result,
    input  logic [XLEN-1:0] writeData,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] oldPC,
    output logic [XLEN-1:0] memData,
    output logic            stall,
    output logic            busErr,
    mem_access_sequencer_if.master bus
);

    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    ms_state_e    state;
    ms_state_e    state_nxt;
    access_kind_e kind;
    access_kind_e kind_in;
    logic         access;
    logic [XLEN-1:0] addr_in;
    logic         start;
    logic         ack_fire;
    logic         timeout_fire;
    logic         cnt_clear;
    logic         cnt_en;
    logic         cnt_tc;

    // Decode the controller strobes into an access request
    always_comb begin
        access  = IRWrite | adrSrc;
        kind_in = decode_kind(IRWrite, memWrite);
        addr_in = IRWrite ? PC : result;
    end

    mem_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .tc_c   (cnt_tc)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= MS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stall and datapath strobes; ack beats a coincident timeout
    always_comb begin
        state_nxt    = state;
        stall        = 1'b0;
        start        = 1'b0;
        ack_fire     = 1'b0;
        timeout_fire = 1'b0;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        case (state)
            MS_IDLE: begin
                stall = access;
                if (access) begin
                    start     = 1'b1;
                    cnt_clear = 1'b1;
                    state_nxt = MS_BUSY;
                end
            end
            MS_BUSY: begin
                stall = 1'b1;
                if (bus.memAck) begin
                    ack_fire  = 1'b1;
                    state_nxt = MS_DONE;
                end else if (cnt_tc) begin
                    timeout_fire = 1'b1;
                    state_nxt    = MS_DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            MS_DONE: begin
                state_nxt = MS_IDLE;
            end
            default: begin
                state_nxt = MS_IDLE;
            end
        endcase
    end

    // Request launch, completion capture and timeout handling
    always_ff @(posedge clk) begin
        if (!rst) begin
            kind         <= AK_FETCH;
            bus.memReq   <= 1'b0;
            bus.memWe    <= 1'b0;
            bus.memAddr  <= '0;
            bus.memWdata <= '0;
            instr        <= NOP_INSTR;
            oldPC        <= '0;
            memData      <= '0;
            busErr       <= 1'b0;
        end else begin
            if (start) begin
                kind         <= kind_in;
                bus.memReq   <= 1'b1;
                bus.memWe    <= (kind_in == AK_STORE);
                bus.memAddr  <= addr_in & WORD_MASK;
                bus.memWdata <= writeData;
                if (kind_in == AK_FETCH) begin
                    oldPC <= PC;
                end
            end
            if (ack_fire) begin
                bus.memReq <= 1'b0;
                bus.memWe  <= 1'b0;
                if (kind == AK_FETCH) begin
                    instr <= bus.memRdata;
                end else if (kind == AK_LOAD) begin
                    memData <= bus.memRdata;
                end
            end
            if (timeout_fire) begin
                bus.memReq <= 1'b0;
                busErr     <= 1'b1;
                if (kind == AK_FETCH) begin
                    instr <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer with a queue-based scoreboard.
module tb_mem_access_sequencer;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned TIMEOUT = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] instr;
        logic [31:0] oldpc;
        logic [31:0] memdata;
        logic        buserr;
        int          stall_len;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        IRWrite;
    logic        adrSrc;
    logic        memWrite;
    logic [31:0] PC;
    logic [31:0] result;
    logic [31:0] writeData;
    logic [31:0] instr;
    logic [31:0] oldPC;
    logic [31:0] memData;
    logic        stall;
    logic        busErr;

    int errors = 0;
    int checks = 0;
    exp_t exp_q[$];

    mem_access_sequencer_if #(.XLEN(XLEN)) bus ();

    mem_access_sequencer #(
        .XLEN      (XLEN),
        .TIMEOUT   (TIMEOUT),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .IRWrite   (IRWrite),
        .adrSrc    (adrSrc),
        .memWrite  (memWrite),
        .PC        (PC),
        .result    (result),
        .writeData (writeData),
        .instr     (instr),
        .oldPC     (oldPC),
        .memData   (memData),
        .stall     (stall),
        .busErr    (busErr),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks live request fields and, when a request retires, the committed registers
    logic prev_req = 1'b0;
    int   stall_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (bus.memReq === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 32'(bus.memReq), 32'd0);
            end else begin
                chk("memAddr", bus.memAddr, exp_q[0].addr);
                chk("memWe", 32'(bus.memWe), 32'(exp_q[0].we));
                chk("memWdata", bus.memWdata, exp_q[0].wdata);
            end
        end
        if (rst !== 1'b1) begin
            if (bus.memReq === 1'b1 && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            prev_req  = 1'b0;
            stall_run = 0;
        end else begin
            if (prev_req && bus.memReq === 1'b0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("instr", instr, e.instr);
                    chk("oldPC", oldPC, e.oldpc);
                    chk("memData", memData, e.memdata);
                    chk("busErr", 32'(busErr), 32'(e.buserr));
                    chk("memWe_done", 32'(bus.memWe), 32'd0);
                    chk("stall_done", 32'(stall), 32'd0);
                    chk("stall_len", 32'(stall_run), 32'(e.stall_len));
                end
            end
            if (stall === 1'b1) begin
                stall_run++;
            end else begin
                stall_run = 0;
            end
            prev_req = (bus.memReq === 1'b1);
        end
    end

    // Drive one controller access; ack_at is the BUSY cycle carrying memAck (0 = never)
    task automatic run_access(
        input logic ir, input logic adr, input logic mw,
        input logic [31:0] pc_v, input logic [31:0] res_v, input logic [31:0] wd_v,
        input int ack_at, input logic [31:0] rd_v, input logic done_ack,
        input logic [31:0] e_addr, input logic e_we, input logic [31:0] e_wdata,
        input logic [31:0] e_instr, input logic [31:0] e_oldpc, input logic [31:0] e_md,
        input logic e_berr, input int e_stall);
        exp_t e;
        int n;
        e.addr = e_addr; e.we = e_we; e.wdata = e_wdata; e.instr = e_instr;
        e.oldpc = e_oldpc; e.memdata = e_md; e.buserr = e_berr; e.stall_len = e_stall;
        exp_q.push_back(e);
        @(posedge clk); #1;
        IRWrite = ir; adrSrc = adr; memWrite = mw;
        PC = pc_v; result = res_v; writeData = wd_v;
        @(posedge clk); #1;
        n = 1;
        while (bus.memReq === 1'b1 && n < 50) begin
            bus.memAck   = (n == ack_at);
            bus.memRdata = rd_v;
            @(posedge clk); #1;
            bus.memAck = 1'b0;
            n++;
        end
        if (n >= 50) begin
            chk("req_bound", 32'(n), 32'd0);
        end
        // DONE cycle: strobes still presented, optionally a spurious ack
        if (done_ack) begin
            bus.memAck   = 1'b1;
            bus.memRdata = 32'hBAD0_BAD0;
        end
        @(posedge clk); #1;
        bus.memAck = 1'b0;
        IRWrite = 1'b0; adrSrc = 1'b0; memWrite = 1'b0;
        if (done_ack) begin
            chk("done_ack_instr", instr, e_instr);
            chk("done_ack_memData", memData, e_md);
            chk("done_ack_memReq", 32'(bus.memReq), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_memReq"}, 32'(bus.memReq), 32'd0);
        chk({tag, "_memWe"}, 32'(bus.memWe), 32'd0);
        chk({tag, "_memAddr"}, bus.memAddr, 32'd0);
        chk({tag, "_memWdata"}, bus.memWdata, 32'd0);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_oldPC"}, oldPC, 32'd0);
        chk({tag, "_memData"}, memData, 32'd0);
        chk({tag, "_busErr"}, 32'(busErr), 32'd0);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; IRWrite = 1'b0; adrSrc = 1'b0; memWrite = 1'b0;
        PC = '0; result = '0; writeData = '0;
        bus.memAck = 1'b0; bus.memRdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b1;

        // Fetch, ack in second BUSY cycle
        run_access(1, 0, 0, 32'h40, 32'h0, 32'h0, 2, 32'h0050_0093, 0,
                   32'h40, 0, 32'h0, 32'h0050_0093, 32'h40, 32'h0, 0, 3);
        // Load from unaligned address, ack in first BUSY cycle
        run_access(0, 1, 0, 32'h0, 32'h106, 32'h0, 1, 32'hDEAD_BEEF, 0,
                   32'h104, 0, 32'h0, 32'h0050_0093, 32'h40, 32'hDEAD_BEEF, 0, 2);
        // Store, ack coincides with the terminal count
        run_access(0, 1, 1, 32'h0, 32'h200, 32'h1234_5678, 4, 32'hCAFE_F00D, 0,
                   32'h200, 1, 32'h1234_5678, 32'h0050_0093, 32'h40, 32'hDEAD_BEEF, 0, 5);

        // Spurious ack while idle
        @(posedge clk); #1;
        bus.memAck = 1'b1; bus.memRdata = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus.memAck = 1'b0;
        chk("idle_ack_instr", instr, 32'h0050_0093);
        chk("idle_ack_memData", memData, 32'hDEAD_BEEF);
        chk("idle_ack_oldPC", oldPC, 32'h40);
        chk("idle_ack_memReq", 32'(bus.memReq), 32'd0);

        // Both strobes set: fetch at PC; spurious ack in DONE
        run_access(1, 1, 1, 32'h80, 32'h300, 32'h55, 1, 32'h00A0_0113, 1,
                   32'h80, 0, 32'h55, 32'h00A0_0113, 32'h80, 32'hDEAD_BEEF, 0, 2);

        // Fetch with no ack: abort after TIMEOUT BUSY cycles
        run_access(1, 0, 0, 32'h44, 32'h0, 32'h0, 0, 32'h0, 0,
                   32'h44, 0, 32'h0, 32'h0000_0013, 32'h44, 32'hDEAD_BEEF, 1, 5);
        repeat (3) @(posedge clk);
        #1;
        chk("busErr_sticky", 32'(busErr), 32'd1);

        // Reset during the second BUSY cycle of a load
        begin
            exp_t e;
            e.addr = 32'h20C; e.we = 1'b0; e.wdata = 32'h0; e.instr = 32'h0;
            e.oldpc = 32'h0; e.memdata = 32'h0; e.buserr = 1'b0; e.stall_len = 0;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        adrSrc = 1'b1; result = 32'h20C; writeData = 32'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; adrSrc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_reset_state("midbusy_reset");
        bus.memAck = 1'b1; bus.memRdata = 32'h7777_7777;
        @(posedge clk); #1;
        bus.memAck = 1'b0;
        chk("late_ack_memData", memData, 32'd0);
        chk("late_ack_instr", instr, 32'h0000_0013);
        chk("late_ack_memReq", 32'(bus.memReq), 32'd0);

        // Normal load after reset
        run_access(0, 1, 0, 32'h0, 32'h10, 32'h0, 1, 32'h1122_3344, 0,
                   32'h10, 0, 32'h0, 32'h0000_0013, 32'h0, 32'h1122_3344, 0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
